// File: rtl/audio_pll_supervisor.sv
// Audio PLL bring-up supervisor: reset pulse, lock timeout with bounded retries, stability qualification, lock-loss detect.
// Build option AUDIO_PLL_SUPERVISOR_AUTORECOVER_EN: lock loss in RUN re-runs the reset sequence instead of faulting.
module audio_pll_supervisor #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int LOCK_STABLE     = 1024,
    parameter int MAX_RETRIES     = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_count
);
    localparam int CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_PLL_RESET, S_WAIT_LOCK, S_STABILIZE, S_RUN, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             meta_q, locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_lost_q, lock_lost_d;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            meta_q      <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            meta_q      <= pll_locked;
            locked_s_q  <= meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                retry_d = '0;
                state_d = S_PLL_RESET;
            end
            S_PLL_RESET: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is tested ahead of the timeout so a coincident lock wins
                if (locked_s_q) begin
                    state_d = S_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_PLL_RESET;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_STABILIZE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
`ifdef AUDIO_PLL_SUPERVISOR_AUTORECOVER_EN
                    state_d = S_PLL_RESET;
                    retry_d = '0;
`else
                    state_d = S_FAULT;
`endif
                end
            end
            S_FAULT: cnt_d = '0;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register in step with state_q
    always_comb begin
        pll_rst_d   = (state_d == S_IDLE) || (state_d == S_PLL_RESET) || (state_d == S_FAULT);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
        lock_lost_d = (state_q == S_RUN) && !locked_s_q;
    end

    assign pll_rst     = pll_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Directed bench for audio_pll_supervisor with small timing parameters; expected cycle counts are hand-derived.
module tb_audio_pll_supervisor;
    localparam int HOLD = 4;
    localparam int TO   = 20;
    localparam int STAB = 8;
    localparam int MAXR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, ready, fault, lock_lost;
    logic [3:0] retry_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int f_cyc = 0;
    int n = 0;

    audio_pll_supervisor #(
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_TIMEOUT   (TO),
        .LOCK_STABLE    (STAB),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .enable     (enable),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fault      (fault),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    // Samples spent with pll_rst at lvl; 200 means the bound expired
    task automatic count_rst(input logic lvl, output int cnt);
        cnt = 0;
        while (pll_rst === lvl && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
    endtask

    // Enable from IDLE, check the reset hold width, leave f_cyc at the pll_rst fall
    task automatic start(input string tag);
        int w;
        enable = 1'b1;
        tick();
        count_rst(1'b1, w);
        check(tag, w, HOLD);
        f_cyc = cyc;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_retry", retry_count, 0);
        rst = 1'b1;
        tick();

        // Nominal bring-up: lock 5 cycles after pll_rst falls
        start("nom_hold");
        tick_to(f_cyc + 5);
        pll_locked = 1'b1;
        wait_ready();
        check("nom_ready_lat", cyc - f_cyc, 16);
        check("nom_retry", retry_count, 0);
        check("nom_pll_rst", pll_rst, 0);
        check("nom_fault", fault, 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        n = 0;
        while (lock_lost !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ll_latency", n, 3);
        check("ll_ready", ready, 0);
        check("ll_pll_rst", pll_rst, 1);
`ifdef AUDIO_PLL_SUPERVISOR_AUTORECOVER_EN
        check("ll_fault", fault, 0);
        check("ll_retry", retry_count, 0);
`else
        check("ll_fault", fault, 1);
`endif
        tick();
        check("ll_pulse_width", lock_lost, 0);
        repeat (5) tick();
`ifdef AUDIO_PLL_SUPERVISOR_AUTORECOVER_EN
        check("ll_no_fault", fault, 0);
`else
        check("ll_fault_sticky", fault, 1);
`endif
        enable = 1'b0;
        tick();
        check("ll_clear_fault", fault, 0);
        check("ll_idle_pll_rst", pll_rst, 1);
        go_idle();

        // Exhausted retries with lock never arriving
        start("ex_hold0");
        for (int p = 0; p <= MAXR; p++) begin
            count_rst(1'b0, n);
            check($sformatf("ex_wait%0d", p), n, TO);
            if (p < MAXR) begin
                check($sformatf("ex_retry%0d", p), retry_count, p + 1);
                count_rst(1'b1, n);
                check($sformatf("ex_hold%0d", p + 1), n, HOLD);
            end else begin
                check("ex_fault", fault, 1);
                check("ex_retry_final", retry_count, MAXR);
            end
        end
        repeat (30) tick();
        check("ex_no_more_pulses", pll_rst, 1);
        check("ex_fault_held", fault, 1);
        enable = 1'b0;
        tick();
        check("ex_clear_fault", fault, 0);
        check("ex_clear_retry", retry_count, 0);
        go_idle();

        // One-cycle glitch observed at stable count 5
        start("gl_hold");
        pll_locked = 1'b1;
        tick_to(f_cyc + 6);
        pll_locked = 1'b0;
        tick_to(f_cyc + 7);
        pll_locked = 1'b1;
        wait_ready();
        check("gl_ready_lat", cyc - f_cyc, 18);
        check("gl_retry", retry_count, 0);
        go_idle();

        // enable dropped in WAIT_LOCK
        start("ab_hold");
        tick_to(f_cyc + 3);
        enable = 1'b0;
        tick();
        check("ab_en_pll_rst", pll_rst, 1);
        check("ab_en_ready", ready, 0);
        go_idle();

        // rst pulsed during STABILIZE, then full restart
        start("ar_hold");
        pll_locked = 1'b1;
        tick_to(f_cyc + 5);
        rst = 1'b0;
        tick();
        check("ar_pll_rst", pll_rst, 1);
        check("ar_ready", ready, 0);
        check("ar_fault", fault, 0);
        check("ar_lock_lost", lock_lost, 0);
        check("ar_retry", retry_count, 0);
        rst = 1'b1;
        start("ar_rehold");
        wait_ready();
        check("ar_ready_lat", cyc - f_cyc, 9);
        go_idle();

        // Lock arrives on the final timeout cycle: lock wins
        start("sim_hold");
        tick_to(f_cyc + 17);
        pll_locked = 1'b1;
        tick_to(f_cyc + TO);
        check("sim_pll_rst", pll_rst, 0);
        check("sim_retry", retry_count, 0);
        wait_ready();
        check("sim_ready_lat", cyc - f_cyc, 28);
        go_idle();

        // Lock one cycle too late: timeout retries
        start("late_hold");
        tick_to(f_cyc + 18);
        pll_locked = 1'b1;
        tick_to(f_cyc + TO);
        check("late_pll_rst", pll_rst, 1);
        check("late_retry", retry_count, 1);
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
